uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised successor to the single-byte UART transmitter. It adds:
- configurable data width,
- run-time parity (none/even/odd) and 1 or 2 stop bits,
- an internal transmit FIFO, so software or upstream logic can queue several words and send them as back-to-back frames.

It sits between a byte-producing source (CPU register bank or stream logic) and the TX pin.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
FIFO_DEPTH, 4, number of FIFO entries, power of 2, minimum 2
CLKDIV_W, 16, width of CLKDIV

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  reset, asynchronous, active-high
CLKDIV  input  CLKDIV_W  bit period = CLKDIV+1 clock cycles
PARITY_MODE  input  2  00 none, 01 even, 10 odd, 11 treated as none
STOP2  input  1  0 = one stop bit, 1 = two stop bits
TX_DIN  input  DATA_BITS  word to enqueue
TX_ENA  input  1  push strobe, one word per high cycle
TX_FULL  output  1  FIFO full
TX_EMPTY  output  1  FIFO empty
TX_COUNT  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy
TX_OVF  output  1  one-cycle pulse: push rejected because FIFO full
TX_BUSY  output  1  high while a frame is on the line
TX_DONE  output  1  one-cycle pulse at end of every frame
TX_SERIAL  output  1  serial line, idle high

Behaviour:
- Reset (RST high, asynchronous) clears FIFO pointers and count and puts the FSM in IDLE. Output values during and after reset:
  - TX_SERIAL=1, TX_BUSY=0, TX_DONE=0, TX_OVF=0
  - TX_EMPTY=1, TX_FULL=0, TX_COUNT=0
- Reset mid-frame aborts the frame immediately: the line returns high and no TX_DONE is generated.
- All outputs are registered.

FIFO:
- Push: TX_ENA=1 and TX_FULL=0 at a rising edge writes TX_DIN; count increments.
- TX_ENA=1 with TX_FULL=1 drops the word and pulses TX_OVF for one cycle.
- Full is evaluated on the current count. A push while full is rejected even if a pop happens on the same edge.
- Simultaneous push and pop (not full): count unchanged.
- No bypass: a word pushed at edge E is first poppable at edge E+1.
- Pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_SERIAL=1, TX_BUSY=0. If FIFO is non-empty at an edge:
  - pop the head word;
  - latch CLKDIV, PARITY_MODE and STOP2 into frame registers;
  - enter START.
- Changing configuration inputs mid-frame has no effect until the next frame.
- Latency: push at edge E0 into an empty FIFO with the FSM idle gives TX_SERIAL=0 and TX_BUSY=1 from edge E0+2.
- START: TX_SERIAL=0 for one bit period.
- DATA: DATA_BITS bits, LSB first, each held one bit period.
- PARITY: entered only if the latched mode is even or odd.
  - even: bit = XOR of data bits.
  - odd: bit = inverted XOR of data bits.
- STOP: TX_SERIAL=1 for 1 or 2 bit periods.
- Bit timer: counts 0..CLKDIV_latched. A bit ends when the timer equals CLKDIV_latched. CLKDIV=0 gives one-cycle bits.
- End of the last stop bit:
  - TX_DONE pulses for that one cycle;
  - if FIFO is non-empty: pop and go directly to START (no idle gap, TX_BUSY stays 1);
  - otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + P + S) × (CLKDIV+1) cycles, where P = 0 or 1 (parity present) and S = 1 or 2 (stop bits).

Test Plan:
1. CLKDIV=3, parity none, STOP2=0, push 0xAB -> TX_SERIAL shows 0,1,1,0,1,0,1,0,1,1 with each bit 4 cycles; TX_DONE pulses once 40 cycles after the start bit begins; then TX_BUSY=0 and TX_EMPTY=1.
2. CLKDIV=3, even parity, push 0x0F, then after TX_DONE switch to odd parity and push 0x0F -> parity bit 0 in the first frame, 1 in the second; each frame 44 cycles.
3. STOP2=1, CLKDIV=1, push 0x55 -> stop level high for exactly 4 cycles before TX_DONE; frame length 22 cycles.
4. Depth 4, FSM idle, 6 consecutive TX_ENA cycles pushing 0x01..0x06 -> first word popped at once, 0x02..0x05 queued, TX_FULL=1 and TX_COUNT=4 after the fifth push, TX_OVF pulses once on 0x06; serial output carries 0x01..0x05 back-to-back with 5 TX_DONE pulses and TX_BUSY continuously high.
5. Assert RST for 2 cycles in the middle of the DATA state of 0xAB with 2 words queued -> TX_SERIAL=1 immediately, TX_COUNT=0, no TX_DONE; a new push afterwards transmits correctly.
6. DATA_BITS=7 instance, odd parity, push 7'h7F -> 7 data ones then parity 0; frame length 10 bit periods.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// UART transmitter with an internal transmit FIFO. Upstream logic queues
// words with TX_ENA/TX_DIN; the frame engine pops them and sends them as
// back-to-back frames on TX_SERIAL.
//
// Frame format: start(0), DATA_BITS data bits LSB first, optional parity
// (even/odd), then 1 or 2 stop bits(1). Each bit lasts CLKDIV+1 clocks.
// CLKDIV, PARITY_MODE and STOP2 are sampled when a word is popped and held
// for the whole frame.
//
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous active-high reset
//   CLKDIV       bit period minus one, in clocks
//   PARITY_MODE  00 none, 01 even, 10 odd, 11 none
//   STOP2        0 = one stop bit, 1 = two stop bits
//   TX_DIN       word to enqueue
//   TX_ENA       push strobe, one word per high cycle
//   TX_FULL      FIFO full
//   TX_EMPTY     FIFO empty
//   TX_COUNT     FIFO occupancy
//   TX_OVF       one-cycle pulse: push dropped because FIFO full
//   TX_BUSY      high while a frame is on the line
//   TX_DONE      one-cycle pulse at the end of every frame
//   TX_SERIAL    serial line, idle high
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | line idle high, waiting for a queued word
// S_START  | start bit (low) for one bit period
// S_DATA   | data bits, LSB first, shift register drains one per bit
// S_PARITY | parity bit, only when the latched mode is even or odd
// S_STOP   | stop bit(s) high; pops the next word at the end if any
//
// All outputs are registered from the current state, so the line level
// trails the state register by one clock. TX_DONE is delayed one more
// clock so it lands right after the last stop-bit clock on the line.

module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CLKDIV_W   = 16
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic [CLKDIV_W-1:0]                CLKDIV,
   input  logic [1:0]                         PARITY_MODE,
   input  logic                               STOP2,
   input  logic [DATA_BITS-1:0]               TX_DIN,
   input  logic                               TX_ENA,
   output logic                               TX_FULL,
   output logic                               TX_EMPTY,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    TX_COUNT,
   output logic                               TX_OVF,
   output logic                               TX_BUSY,
   output logic                               TX_DONE,
   output logic                               TX_SERIAL
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS-1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 full_q, full_d;
   logic                 empty_q, empty_d;
   logic                 ovf_q, ovf_d;
   logic                 push_ok;
   logic                 pop;
   logic [DATA_BITS-1:0] head_word;

   // frame engine
   state_t               state_q, state_d;
   logic [CLKDIV_W-1:0]  timer_q, timer_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 stop_sec_q, stop_sec_d;
   logic [CLKDIV_W-1:0]  div_q, div_d;
   logic [1:0]           pmode_q, pmode_d;
   logic                 stop2_q, stop2_d;
   logic                 frame_end_q, frame_end_d;
   logic                 start_frame;
   logic                 tick;
   logic                 has_par;

   // output registers
   logic                 serial_q, serial_d;
   logic                 busy_q, busy_d;
   logic                 done_q;

   assign head_word = mem_q[rd_ptr_q];
   // Full is judged on the current count, so a push while full is dropped
   // even when a pop happens on the same edge.
   assign push_ok   = TX_ENA & ~full_q;
   assign tick      = (timer_q == div_q);
   assign has_par   = (pmode_q == 2'b01) || (pmode_q == 2'b10);

   // ---------------------------------------------------------------
   // FIFO next state
   // ---------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
      ovf_d   = TX_ENA & full_q;
   end

   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= TX_DIN;
      end
   end

   // ---------------------------------------------------------------
   // Frame engine next state
   // ---------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      par_d       = par_q;
      stop_sec_d  = stop_sec_q;
      div_d       = div_q;
      pmode_d     = pmode_q;
      stop2_d     = stop2_q;
      frame_end_d = 1'b0;
      start_frame = 1'b0;
      pop         = 1'b0;

      if (state_q != S_IDLE) begin
         timer_d = tick ? '0 : timer_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (!empty_q) begin
               start_frame = 1'b1;
            end
         end
         S_START: begin
            if (tick) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_q == LAST_BIT) begin
                  stop_sec_d = 1'b0;
                  state_d    = has_par ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               stop_sec_d = 1'b0;
               state_d    = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (stop2_q && !stop_sec_q) begin
                  stop_sec_d = 1'b1;
               end else begin
                  frame_end_d = 1'b1;
                  if (!empty_q) begin
                     start_frame = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Popping a word also snapshots the line configuration, so changes on
      // the configuration inputs mid-frame only affect later frames.
      if (start_frame) begin
         pop      = 1'b1;
         state_d  = S_START;
         timer_d  = '0;
         shift_d  = head_word;
         div_d    = CLKDIV;
         pmode_d  = PARITY_MODE;
         stop2_d  = STOP2;
         par_d    = (^head_word) ^ (PARITY_MODE == 2'b10);
      end
   end

   // ---------------------------------------------------------------
   // Output next state (from the current state)
   // ---------------------------------------------------------------
   always_comb begin
      serial_d = 1'b1;
      busy_d   = (state_q != S_IDLE);
      case (state_q)
         S_IDLE:   serial_d = 1'b1;
         S_START:  serial_d = 1'b0;
         S_DATA:   serial_d = shift_q[0];
         S_PARITY: serial_d = par_q;
         S_STOP:   serial_d = 1'b1;
         default:  serial_d = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         ovf_q       <= 1'b0;
         state_q     <= S_IDLE;
         timer_q     <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         stop_sec_q  <= 1'b0;
         div_q       <= '0;
         pmode_q     <= '0;
         stop2_q     <= 1'b0;
         frame_end_q <= 1'b0;
         serial_q    <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         ovf_q       <= ovf_d;
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         stop_sec_q  <= stop_sec_d;
         div_q       <= div_d;
         pmode_q     <= pmode_d;
         stop2_q     <= stop2_d;
         frame_end_q <= frame_end_d;
         serial_q    <= serial_d;
         busy_q      <= busy_d;
         done_q      <= frame_end_q;
      end
   end

   assign TX_FULL   = full_q;
   assign TX_EMPTY  = empty_q;
   assign TX_COUNT  = count_q;
   assign TX_OVF    = ovf_q;
   assign TX_BUSY   = busy_q;
   assign TX_DONE   = done_q;
   assign TX_SERIAL = serial_q;

endmodule
